spike_rate_meter: RTL and testbench

SPIKE_RATE_METER -- requirements
Module: spike_rate_meter

---
 rtl/spike_rate_meter_pkg.sv | 17 +
 rtl/spike_edge_isi.sv | 61 ++++++
 rtl/spike_rate_meter.sv | 157 +++++++++++++++
 tb/tb_spike_rate_meter.sv | 167 ++++++++++++++++
 4 files changed

// File: rtl/spike_rate_meter_pkg.sv
// rtl/spike_rate_meter_pkg.sv - shared types and constants for the spike rate meter
package spike_rate_meter_pkg;

  localparam int DATA_W = 8;
  localparam logic [DATA_W-1:0] ISI_SAT = 8'd255;

  typedef enum logic {
    IDLE  = 1'b0,
    COUNT = 1'b1
  } fsm_state_t;

  function automatic logic [DATA_W-1:0] umax(input logic [DATA_W-1:0] a,
                                             input logic [DATA_W-1:0] b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/spike_edge_isi.sv
// rtl/spike_edge_isi.sv - spike rising-edge detector and per-window minimum ISI tracker
module spike_edge_isi
  import spike_rate_meter_pkg::*;
(
  input  logic              clk,
  input  logic              reset_n,
  input  logic              spike,
  input  logic              sample_en,
  input  logic              win_first,
  input  logic [DATA_W-1:0] sample_idx,
  output logic              spike_event,
  output logic [DATA_W-1:0] isi_min_next
);

  logic              spike_d_q, spike_d_d;
  logic              have_q, have_d;
  logic [DATA_W-1:0] last_q, last_d;
  logic [DATA_W-1:0] min_q, min_d;

  logic              base_have;
  logic [DATA_W-1:0] base_min;
  logic [DATA_W-1:0] isi;

  // The first sample of a window ignores stale history, so no explicit clear is needed on abort.
  always_comb begin
    spike_d_d    = spike;
    spike_event  = spike & ~spike_d_q;
    base_have    = win_first ? 1'b0 : have_q;
    base_min     = win_first ? ISI_SAT : min_q;
    isi          = sample_idx - last_q;
    isi_min_next = base_min;
    have_d       = have_q;
    last_d       = last_q;
    min_d        = min_q;
    if (spike_event && base_have && (isi < base_min)) begin
      isi_min_next = isi;
    end
    if (sample_en) begin
      have_d = base_have | spike_event;
      min_d  = isi_min_next;
      if (spike_event) begin
        last_d = sample_idx;
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      spike_d_q <= 1'b0;
      have_q    <= 1'b0;
      last_q    <= '0;
      min_q     <= ISI_SAT;
    end else begin
      spike_d_q <= spike_d_d;
      have_q    <= have_d;
      last_q    <= last_d;
      min_q     <= min_d;
    end
  end

endmodule

// File: rtl/spike_rate_meter.sv
// rtl/spike_rate_meter.sv - windowed spike count, peak state and min ISI with a valid/ready result
module spike_rate_meter
  import spike_rate_meter_pkg::*;
(
  input  logic              clk,
  input  logic              reset_n,
  input  logic              spike,
  input  logic [DATA_W-1:0] state,
  input  logic              enable,
  input  logic [DATA_W-1:0] win_len,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] rate,
  output logic [DATA_W-1:0] peak,
  output logic [DATA_W-1:0] isi_min,
  output logic              overrun
);

  fsm_state_t        fsm_q, fsm_d;
  logic [DATA_W-1:0] cnt_q, cnt_d;
  logic [DATA_W-1:0] last_idx_q, last_idx_d;
  logic [DATA_W-1:0] acc_cnt_q, acc_cnt_d;
  logic [DATA_W-1:0] acc_peak_q, acc_peak_d;
  logic [DATA_W-1:0] rate_q, rate_d;
  logic [DATA_W-1:0] peak_q, peak_d;
  logic [DATA_W-1:0] isi_q, isi_d;
  logic              valid_q, valid_d;
  logic              ovr_q, ovr_d;

  logic              sampling;
  logic              win_first;
  logic              win_last;
  logic              spike_event;
  logic [DATA_W-1:0] isi_min_next;
  logic [DATA_W-1:0] base_cnt;
  logic [DATA_W-1:0] cnt_next;
  logic [DATA_W-1:0] peak_next;

  spike_edge_isi u_edge_isi (
    .clk          (clk),
    .reset_n      (reset_n),
    .spike        (spike),
    .sample_en    (sampling),
    .win_first    (win_first),
    .sample_idx   (cnt_q),
    .spike_event  (spike_event),
    .isi_min_next (isi_min_next)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      fsm_q <= IDLE;
    end else begin
      fsm_q <= fsm_d;
    end
  end

  always_comb begin
    fsm_d = fsm_q;
    case (fsm_q)
      IDLE: begin
        if (enable) fsm_d = COUNT;
      end
      COUNT: begin
        if (win_last) fsm_d = enable ? COUNT : IDLE;
        else if (!enable) fsm_d = IDLE;
      end
      default: fsm_d = IDLE;
    endcase
  end

  // last_idx holds N-1; win_len=0 wraps to 255, which gives the 256-cycle window for free.
  always_comb begin
    sampling  = (fsm_q == COUNT);
    win_first = sampling && (cnt_q == '0);
    win_last  = sampling && (cnt_q == last_idx_q);
  end

  always_comb begin
    cnt_d      = cnt_q;
    last_idx_d = last_idx_q;
    if (fsm_q == IDLE) begin
      cnt_d = '0;
      if (enable) last_idx_d = win_len - 8'd1;
    end else if (win_last) begin
      cnt_d      = '0;
      last_idx_d = win_len - 8'd1;
    end else if (!enable) begin
      cnt_d = '0;
    end else begin
      cnt_d = cnt_q + 8'd1;
    end
  end

  always_comb begin
    base_cnt   = win_first ? '0 : acc_cnt_q;
    cnt_next   = (spike_event && (base_cnt != 8'hFF)) ? base_cnt + 8'd1 : base_cnt;
    peak_next  = umax(win_first ? '0 : acc_peak_q, state);
    acc_cnt_d  = acc_cnt_q;
    acc_peak_d = acc_peak_q;
    if (sampling) begin
      acc_cnt_d  = cnt_next;
      acc_peak_d = peak_next;
    end
  end

  // A load on a handshake edge keeps valid high without flagging overrun.
  always_comb begin
    rate_d  = rate_q;
    peak_d  = peak_q;
    isi_d   = isi_q;
    valid_d = valid_q;
    ovr_d   = ovr_q;
    if (win_last) begin
      rate_d  = cnt_next;
      peak_d  = peak_next;
      isi_d   = isi_min_next;
      valid_d = 1'b1;
      if (valid_q && !out_ready) ovr_d = 1'b1;
    end else if (valid_q && out_ready) begin
      valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cnt_q      <= '0;
      last_idx_q <= '0;
      acc_cnt_q  <= '0;
      acc_peak_q <= '0;
      rate_q     <= '0;
      peak_q     <= '0;
      isi_q      <= ISI_SAT;
      valid_q    <= 1'b0;
      ovr_q      <= 1'b0;
    end else begin
      cnt_q      <= cnt_d;
      last_idx_q <= last_idx_d;
      acc_cnt_q  <= acc_cnt_d;
      acc_peak_q <= acc_peak_d;
      rate_q     <= rate_d;
      peak_q     <= peak_d;
      isi_q      <= isi_d;
      valid_q    <= valid_d;
      ovr_q      <= ovr_d;
    end
  end

  always_comb begin
    out_valid = valid_q;
    rate      = rate_q;
    peak      = peak_q;
    isi_min   = isi_q;
    overrun   = ovr_q;
  end

endmodule

// File: tb/tb_spike_rate_meter.sv
// tb/tb_spike_rate_meter.sv - directed vector bench for spike_rate_meter
module tb_spike_rate_meter;

  logic       clk = 1'b0;
  logic       reset_n;
  logic       spike;
  logic [7:0] state;
  logic       enable;
  logic [7:0] win_len;
  logic       out_valid;
  logic       out_ready;
  logic [7:0] rate;
  logic [7:0] peak;
  logic [7:0] isi_min;
  logic       overrun;

  int checks = 0;
  int errors = 0;

  spike_rate_meter dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .spike     (spike),
    .state     (state),
    .enable    (enable),
    .win_len   (win_len),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .rate      (rate),
    .peak      (peak),
    .isi_min   (isi_min),
    .overrun   (overrun)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [7:0]  win_len;
    logic [15:0] spike_bits;
    logic        toggle;
    logic [7:0]  st0, st1, st2, st3, st_rest;
    logic [7:0]  exp_rate, exp_peak, exp_isi;
  } vec_t;

  vec_t vecs[6];

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic step();
    @(negedge clk);
  endtask

  task automatic check_result(input string tag, input int v, input int r, input int p,
                              input int i, input int o);
    check({tag, " out_valid"}, out_valid, v);
    check({tag, " rate"}, rate, r);
    check({tag, " peak"}, peak, p);
    check({tag, " isi_min"}, isi_min, i);
    check({tag, " overrun"}, overrun, o);
  endtask

  task automatic run_vec(input int k);
    vec_t v;
    int   n;
    logic [15:0] bits;
    v    = vecs[k];
    bits = v.spike_bits;
    n    = (v.win_len == 0) ? 256 : int'(v.win_len);
    enable = 1'b1; win_len = v.win_len; spike = 1'b0; out_ready = 1'b0;
    step();
    win_len = ~v.win_len;
    for (int i = 0; i < n; i++) begin
      if (v.toggle) spike = i[0];
      else spike = (i < 16) ? bits[i] : 1'b0;
      case (i)
        0: state = v.st0;
        1: state = v.st1;
        2: state = v.st2;
        3: state = v.st3;
        default: state = v.st_rest;
      endcase
      enable = (i != n - 1);
      step();
      if (i == n - 2) check($sformatf("vec%0d valid before last", k), out_valid, 0);
    end
    check_result($sformatf("vec%0d", k), 1, v.exp_rate, v.exp_peak, v.exp_isi, 0);
    spike = 1'b0; out_ready = 1'b1;
    step();
    check($sformatf("vec%0d consume", k), out_valid, 0);
    out_ready = 1'b0;
  endtask

  task automatic drive(input logic s, input logic [7:0] st, input logic en);
    spike = s; state = st; enable = en;
    step();
  endtask

  initial begin
    vecs[0] = '{8'd10, 16'h004C, 1'b0, 8'd10, 8'd20, 8'd30, 8'd40, 8'd7, 8'd2, 8'd40, 8'd4};
    vecs[1] = '{8'd0, 16'h0000, 1'b1, 8'd0, 8'd0, 8'd0, 8'd0, 8'd99, 8'd128, 8'd99, 8'd2};
    vecs[2] = '{8'd4, 16'h0002, 1'b0, 8'd5, 8'd200, 8'd17, 8'd3, 8'd0, 8'd1, 8'd200, 8'd255};
    vecs[3] = '{8'd3, 16'h0007, 1'b0, 8'd1, 8'd2, 8'd3, 8'd0, 8'd0, 8'd1, 8'd3, 8'd255};
    vecs[4] = '{8'd5, 16'h0015, 1'b0, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0, 8'd3, 8'd0, 8'd2};
    vecs[5] = '{8'd1, 16'h0001, 1'b0, 8'd250, 8'd0, 8'd0, 8'd0, 8'd0, 8'd1, 8'd250, 8'd255};

    reset_n = 1'b0; spike = 1'b0; state = 8'd0; enable = 1'b0; win_len = 8'd0; out_ready = 1'b0;
    step();
    step();
    reset_n = 1'b1;
    step();
    check_result("reset", 0, 0, 0, 255, 0);

    for (int k = 0; k < 6; k++) run_vec(k);

    // Back-to-back windows with no consumer: second result overwrites the first.
    out_ready = 1'b0; win_len = 8'd2; enable = 1'b1; spike = 1'b0;
    step();
    drive(1'b1, 8'd9, 1'b1);
    drive(1'b0, 8'd1, 1'b1);
    check_result("b2b first", 1, 1, 9, 255, 0);
    drive(1'b0, 8'd4, 1'b1);
    drive(1'b1, 8'd50, 1'b0);
    check_result("b2b second", 1, 1, 50, 255, 1);
    spike = 1'b0; out_ready = 1'b1;
    step();
    check("b2b consume valid", out_valid, 0);
    check("b2b overrun sticky", overrun, 1);
    out_ready = 1'b0;

    // Abort at sample index 3 of an 8-cycle window.
    win_len = 8'd8; enable = 1'b1;
    step();
    drive(1'b0, 8'd255, 1'b1);
    drive(1'b1, 8'd255, 1'b1);
    drive(1'b0, 8'd255, 1'b1);
    drive(1'b1, 8'd255, 1'b0);
    spike = 1'b0;
    for (int i = 0; i < 10; i++) step();
    check_result("abort", 0, 1, 50, 255, 1);

    // Asynchronous reset mid-window, then a clean window from IDLE.
    win_len = 8'd8; enable = 1'b1;
    step();
    drive(1'b1, 8'd77, 1'b1);
    drive(1'b0, 8'd77, 1'b1);
    #2 reset_n = 1'b0;
    #1 check_result("async reset", 0, 0, 0, 255, 0);
    enable = 1'b1; win_len = 8'd2; spike = 1'b0; state = 8'd0;
    step();
    reset_n = 1'b1;
    step();
    drive(1'b0, 8'd3, 1'b1);
    check("post reset valid early", out_valid, 0);
    drive(1'b1, 8'd4, 1'b0);
    check_result("post reset", 1, 1, 4, 255, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
